md_scheduler: RTL and testbench



---
 rtl/md_pkg.sv | 28 ++
 rtl/md_scheduler_if.sv | 37 +++
 rtl/md_compute.sv | 72 +++++++
 rtl/md_scheduler.sv | 106 ++++++++++
 tb/tb_md_scheduler.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler: op codes,
// FSM state encoding and default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  function automatic logic md_is_arith(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// EX/ID-side signal bundle of the HI/LO scheduler. The abort input is only
// present when MD_ABORT_EN is defined.
interface md_scheduler_if;
  logic        ex_op_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        id_md_use;
`ifdef MD_ABORT_EN
  logic        abort;
`endif
  logic [31:0] hi;
  logic [31:0] lo;
  logic        start;
  logic        busy;
  logic        stall_id;

`ifdef MD_ABORT_EN
  modport master (
    output ex_op_valid, ex_op, ex_a, ex_b, id_md_use, abort,
    input  hi, lo, start, busy, stall_id
  );
  modport slave (
    input  ex_op_valid, ex_op, ex_a, ex_b, id_md_use, abort,
    output hi, lo, start, busy, stall_id
  );
`else
  modport master (
    output ex_op_valid, ex_op, ex_a, ex_b, id_md_use,
    input  hi, lo, start, busy, stall_id
  );
  modport slave (
    input  ex_op_valid, ex_op, ex_a, ex_b, id_md_use,
    output hi, lo, start, busy, stall_id
  );
`endif
endinterface

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath producing the HI/LO result pair,
// including the divide-by-zero and signed-overflow cases.
module md_compute
  import md_pkg::*;
(
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;
  logic        w_div_zero;
  logic        w_div_ovf;

  assign w_prod_s   = $signed({{32{ex_a[31]}}, ex_a}) * $signed({{32{ex_b[31]}}, ex_b});
  assign w_prod_u   = {32'd0, ex_a} * {32'd0, ex_b};
  assign w_quo_s    = $signed(ex_a) / $signed(ex_b);
  assign w_rem_s    = $signed(ex_a) % $signed(ex_b);
  assign w_quo_u    = ex_a / ex_b;
  assign w_rem_u    = ex_a % ex_b;
  assign w_div_zero = (ex_b == 32'd0);
  // Most-negative / -1 cannot be represented; pin it instead of trusting the divider.
  assign w_div_ovf  = (ex_a == 32'h8000_0000) && (ex_b == 32'hFFFF_FFFF);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op_e'(ex_op))
      MD_MULT: begin
        res_hi = w_prod_s[63:32];
        res_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = w_prod_u[63:32];
        res_lo = w_prod_u[31:0];
      end
      MD_DIV: begin
        if (w_div_zero) begin
          res_hi = ex_a;
          res_lo = 32'hFFFF_FFFF;
        end else if (w_div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = w_rem_s;
          res_lo = w_quo_s;
        end
      end
      MD_DIVU: begin
        if (w_div_zero) begin
          res_hi = ex_a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = w_rem_u;
          res_lo = w_quo_u;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// HI/LO sequencer: latches a mult/div result, holds it for a fixed latency,
// then commits it. Optional feature macro: MD_ABORT_EN (adds the abort input).
module md_scheduler
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
  input  logic           clk,
  input  logic           reset,
  md_scheduler_if.slave  md
);

  localparam logic [3:0] MULT_LAT_M1 = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAT_M1  = 4'(DIV_CYCLES - 1);

  md_state_e   r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;

  md_op_e      w_op;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_start;
  logic        w_abort;
  logic        w_mt_ok;
  logic [3:0]  w_lat_m1;

  assign w_op = md_op_e'(md.ex_op);

`ifdef MD_ABORT_EN
  assign w_abort = md.abort;
`else
  assign w_abort = 1'b0;
`endif

  md_compute u_compute (
    .ex_op  (md.ex_op),
    .ex_a   (md.ex_a),
    .ex_b   (md.ex_b),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo)
  );

  assign w_start  = md.ex_op_valid & md_is_arith(w_op) & (r_state == ST_IDLE);
  assign w_mt_ok  = md.ex_op_valid & ~w_abort & (r_state == ST_IDLE);
  assign w_lat_m1 = ((w_op == MD_MULT) || (w_op == MD_MULTU)) ? MULT_LAT_M1 : DIV_LAT_M1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start && !w_abort) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_cnt     <= w_lat_m1;
            r_busy    <= 1'b1;
            r_state   <= ST_BUSY;
          end else if (w_mt_ok && (w_op == MD_MTHI)) begin
            r_hi <= md.ex_a;
          end else if (w_mt_ok && (w_op == MD_MTLO)) begin
            r_lo <= md.ex_a;
          end
        end
        ST_BUSY: begin
          // EX ops arriving here are ignored; the stall unit keeps them out.
          if (w_abort) begin
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign md.hi       = r_hi;
  assign md.lo       = r_lo;
  assign md.busy     = r_busy;
  assign md.start    = w_start;
  assign md.stall_id = md.id_md_use & (r_busy | w_start);

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: expected HI/LO pairs are queued at issue
// and checked at commit, along with busy length, hold and stall behaviour.
module tb_md_scheduler;

  localparam int LAT_MULT = 5;
  localparam int LAT_DIV  = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  md_scheduler_if ifc ();

  md_scheduler #(
    .MULT_CYCLES (LAT_MULT),
    .DIV_CYCLES  (LAT_DIV)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .md    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: signed divide done on magnitudes, signs applied afterwards.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] r;
    logic [31:0] ma, mb, q, rm;
    longint      p;
    r = '0;
    case (op)
      3'd1: begin
        p = longint'(signed'(a)) * longint'(signed'(b));
        r = p;
      end
      3'd2: r = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          ma = a[31] ? -a : a;
          mb = b[31] ? -b : b;
          q  = ma / mb;
          rm = ma % mb;
          if (a[31] ^ b[31]) q = -q;
          if (a[31]) rm = -rm;
          r = {rm, q};
        end
      end
      3'd4: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // An EX op must never reach the block while it is busy.
  always @(negedge clk) begin
    #2;
    if (!reset && ifc.ex_op_valid && (ifc.ex_op inside {[3'd1:3'd6]}))
      chk("op_while_busy", {63'd0, ifc.busy}, 64'd0);
  end

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ifc.ex_op_valid = 1'b1;
    ifc.ex_op       = op;
    ifc.ex_a        = a;
    ifc.ex_b        = b;
  endtask

  task automatic clear_op();
    ifc.ex_op_valid = 1'b0;
    ifc.ex_op       = 3'd0;
  endtask

  task automatic do_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit use_id);
    logic [31:0] pre_hi, pre_lo;
    logic [63:0] m;
    exp_t        e;
    int          n;
    pre_hi = ifc.hi;
    pre_lo = ifc.lo;
    m = model(op, a, b);
    e.hi  = m[63:32];
    e.lo  = m[31:0];
    e.lat = (op <= 3'd2) ? LAT_MULT : LAT_DIV;
    sb.push_back(e);
    drive_op(op, a, b);
    ifc.id_md_use = use_id;
    #1;
    chk({tag, "_start"}, {63'd0, ifc.start}, 64'd1);
    if (use_id) chk({tag, "_stall_start"}, {63'd0, ifc.stall_id}, 64'd1);
    @(negedge clk);
    clear_op();
    #1;
    n = 0;
    while (ifc.busy && n < 40) begin
      n++;
      chk({tag, "_hold"}, {ifc.hi, ifc.lo}, {pre_hi, pre_lo});
      if (use_id) chk({tag, "_stall_busy"}, {63'd0, ifc.stall_id}, 64'd1);
      @(negedge clk);
      #1;
    end
    ifc.id_md_use = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_busy_len"}, 64'(n), 64'(e.lat));
      chk({tag, "_hilo"}, {ifc.hi, ifc.lo}, {e.hi, e.lo});
    end
    if (use_id) begin
      ifc.id_md_use = 1'b1;
      #1;
      chk({tag, "_stall_after"}, {63'd0, ifc.stall_id}, 64'd0);
      ifc.id_md_use = 1'b0;
    end
    $display("txn %s op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", tag, op, a, b, n, ifc.hi, ifc.lo);
  endtask

  task automatic do_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    logic [31:0] exp_hi, exp_lo;
    exp_hi = (op == 3'd5) ? a : ifc.hi;
    exp_lo = (op == 3'd6) ? a : ifc.lo;
    drive_op(op, a, 32'd0);
    #1;
    chk({tag, "_start"}, {63'd0, ifc.start}, 64'd0);
    @(negedge clk);
    clear_op();
    #1;
    chk({tag, "_hilo"}, {ifc.hi, ifc.lo}, {exp_hi, exp_lo});
    chk({tag, "_busy"}, {63'd0, ifc.busy}, 64'd0);
    $display("txn %s op=%0d a=%h hi=%h lo=%h", tag, op, a, ifc.hi, ifc.lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_op();
    ifc.ex_a      = 32'd0;
    ifc.ex_b      = 32'd0;
    ifc.id_md_use = 1'b0;
`ifdef MD_ABORT_EN
    ifc.abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_hilo", {ifc.hi, ifc.lo}, 64'd0);
    chk("rst_busy", {63'd0, ifc.busy}, 64'd0);
    chk("rst_start", {63'd0, ifc.start}, 64'd0);
    chk("rst_stall", {63'd0, ifc.stall_id}, 64'd0);

    do_md("mult", 3'd1, 32'd3, 32'hFFFF_FFFE, 1'b0);
    chk("mult_const", {ifc.hi, ifc.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_md("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_const", {ifc.hi, ifc.lo}, 64'h0000_0001_FFFF_FFFE);
    do_md("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_const", {ifc.hi, ifc.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_md("divu0", 3'd4, 32'd5, 32'd0, 1'b0);
    chk("divu0_const", {ifc.hi, ifc.lo}, 64'h0000_0005_FFFF_FFFF);
    do_md("div0", 3'd3, 32'hFFFF_FF00, 32'd0, 1'b0);
    do_md("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divovf_const", {ifc.hi, ifc.lo}, 64'h0000_0000_8000_0000);
    do_md("stall", 3'd1, 32'd7, 32'd9, 1'b1);
    do_mt("mthi", 3'd5, 32'h0000_1234);
    chk("mthi_const", {32'd0, ifc.hi}, 64'h1234);
    do_mt("mtlo", 3'd6, 32'hCAFE_0001);

    // Reset landing in busy cycle 3 of a div discards it.
    drive_op(3'd3, 32'd100, 32'd7);
    sb.push_back('{hi: 32'd0, lo: 32'd0, lat: LAT_DIV});
    @(negedge clk);
    clear_op();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    void'(sb.pop_front());
    chk("rstmid_busy", {63'd0, ifc.busy}, 64'd0);
    chk("rstmid_hilo", {ifc.hi, ifc.lo}, 64'd0);
    $display("txn rstmid busy=%0d hi=%h lo=%h", ifc.busy, ifc.hi, ifc.lo);
    do_md("after_rst", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 300)));
      do_md("rand", rop, ra, rb, 1'(i % 2));
    end

`ifdef MD_ABORT_EN
    begin
      logic [31:0] ph, pl;
      ph = ifc.hi;
      pl = ifc.lo;
      drive_op(3'd1, 32'd11, 32'd13);
      @(negedge clk);
      clear_op();
      @(negedge clk);
      ifc.abort = 1'b1;
      @(negedge clk);
      ifc.abort = 1'b0;
      #1;
      chk("abort_busy", {63'd0, ifc.busy}, 64'd0);
      chk("abort_hilo", {ifc.hi, ifc.lo}, {ph, pl});
      repeat (LAT_MULT) @(negedge clk);
      #1;
      chk("abort_late_hilo", {ifc.hi, ifc.lo}, {ph, pl});
      $display("txn abort busy=%0d hi=%h lo=%h", ifc.busy, ifc.hi, ifc.lo);
      drive_op(3'd2, 32'd11, 32'd13);
      ifc.abort = 1'b1;
      @(negedge clk);
      clear_op();
      ifc.abort = 1'b0;
      #1;
      chk("abort_start_busy", {63'd0, ifc.busy}, 64'd0);
      chk("abort_start_hilo", {ifc.hi, ifc.lo}, {ph, pl});
      $display("txn abort_start busy=%0d hi=%h lo=%h", ifc.busy, ifc.hi, ifc.lo);
      do_md("after_abort", 3'd4, 32'd1000, 32'd3, 1'b0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
